// File: rtl/calculator_pkg.sv
// Shared types and seven-segment helpers for the calculator display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package calculator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Decimal digit to active-low segments; non-decimal codes render blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/accum_display_if.sv
// Accumulator-in / display-out bundle between the calculator and its display stage.
interface accum_display_if #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned NUM_DIGITS = 8
);
  logic [BITS-1:0]       accum;
  logic [NUM_DIGITS-1:0] anode;
  logic [7:0]            cathode;
  logic                  busy;
  logic                  overflow;

  modport master (output accum, input anode, input cathode, input busy, input overflow);
  modport slave  (input accum, output anode, output cathode, output busy, output overflow);
endinterface

// File: rtl/seven_seg_mux.sv
// Time-multiplexed scan of NUM_DIGITS active-low segment patterns onto a
// common-cathode bus; anode is one-hot-low, all outputs registered.
module seven_seg_mux #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_DIGITS-1:0][7:0] seg_in,
  output logic [NUM_DIGITS-1:0]      anode,
  output logic [7:0]                 cathode
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]            cathode_q, cathode_d;

  always_comb begin
    div_d     = div_q + DIV_W'(1);
    idx_d     = idx_q;
    anode_d   = ~(NUM_DIGITS'(1) << idx_q);
    cathode_d = seg_in[idx_q];
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      idx_q     <= '0;
      anode_q   <= '1;
      cathode_q <= '1;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: rtl/accum_display.sv
// Accumulator-to-decimal display: sequential double-dabble conversion on every
// accum change, then multiplexed seven-segment drive. Define
// ACCUM_DISPLAY_SIGNED_EN to treat accum as two's complement with a "-" digit.
module accum_display
  import calculator_pkg::*;
#(
  parameter int unsigned BITS        = 32,
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic            clk,
  input  logic            reset,
  accum_display_if.slave  bus
);

  localparam int unsigned DEC_DIGITS = (BITS * 77) / 256 + 1;
  localparam int unsigned BCD_W      = 4 * DEC_DIGITS;
  localparam int unsigned CNT_W      = (BITS > 1) ? $clog2(BITS) : 1;
`ifdef ACCUM_DISPLAY_SIGNED_EN
  localparam int unsigned USABLE     = NUM_DIGITS - 1;
`else
  localparam int unsigned USABLE     = NUM_DIGITS;
`endif

  typedef logic [NUM_DIGITS-1:0][7:0] disp_t;

  state_t            state_q, state_d;
  logic [BITS-1:0]   last_q, last_d;
  logic [BITS-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dirty_q, dirty_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  disp_t             disp_q, disp_d;

  logic [BITS-1:0]   mag_c;
  logic [BCD_W-1:0]  bcd_adj_c;
  int unsigned       msd_c;
  logic              ovf_c;
  disp_t             seg_c;

`ifdef ACCUM_DISPLAY_SIGNED_EN
  logic              sign_q, sign_d;
  // Negating the most negative value wraps back to 2^(BITS-1), read unsigned.
  assign mag_c = bus.accum[BITS-1] ? (~bus.accum + BITS'(1)) : bus.accum;
`else
  assign mag_c = bus.accum;
`endif

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Render finished BCD: blanking above the top digit, overflow dashes, sign.
  always_comb begin
    msd_c = 0;
    ovf_c = 1'b0;
    for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msd_c = i;
        if (i >= USABLE) ovf_c = 1'b1;
      end
    end
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      seg_c[d] = {1'b1, SEG_BLANK};
      if (ovf_c) begin
        seg_c[d] = {1'b1, SEG_MINUS};
      end else if (d <= msd_c) begin
        seg_c[d] = {1'b1, seg_encode(4'(bcd_q >> (4 * d)))};
      end
`ifdef ACCUM_DISPLAY_SIGNED_EN
      else if (sign_q && (d == msd_c + 1)) begin
        seg_c[d] = {1'b1, SEG_MINUS};
      end
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    dirty_d    = dirty_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    disp_d     = disp_q;
`ifdef ACCUM_DISPLAY_SIGNED_EN
    sign_d     = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (dirty_q || (bus.accum != last_q)) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        last_d  = bus.accum;
        bin_d   = mag_c;
        bcd_d   = '0;
        cnt_d   = '0;
        dirty_d = 1'b0;
`ifdef ACCUM_DISPLAY_SIGNED_EN
        sign_d  = bus.accum[BITS-1];
`endif
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = BCD_W'({bcd_adj_c, bin_q[BITS-1]});
        bin_d = {bin_q[BITS-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BITS - 1)) state_d = DONE;
      end
      DONE: begin
        disp_d     = seg_c;
        overflow_d = ovf_c;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      dirty_q    <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '1;
`ifdef ACCUM_DISPLAY_SIGNED_EN
      sign_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
`ifdef ACCUM_DISPLAY_SIGNED_EN
      sign_q     <= sign_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

  seven_seg_mux #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_mux (
    .clk     (clk),
    .reset   (reset),
    .seg_in  (disp_q),
    .anode   (bus.anode),
    .cathode (bus.cathode)
  );

endmodule

// File: tb/tb_accum_display.sv
// Randomized bench for accum_display against a decimal-arithmetic display model.
module tb_accum_display;

  localparam int unsigned BITS = 32;
  localparam int unsigned N    = 8;
  localparam int unsigned R    = 4;
  localparam int unsigned LAT  = BITS + 2;

  typedef logic [N-1:0][7:0] disp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accum_display_if #(.BITS(BITS), .NUM_DIGITS(N)) bus ();

  accum_display #(.BITS(BITS), .NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Active-high gfedcba glyphs for 0..9.
  logic [6:0] glyph [10];
  initial glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic longint unsigned magnitude(input logic [BITS-1:0] v);
`ifdef ACCUM_DISPLAY_SIGNED_EN
    if (v[BITS-1]) return (64'd1 << BITS) - longint'(v);
`endif
    return longint'(v);
  endfunction

  function automatic bit is_overflow(input logic [BITS-1:0] v);
    longint unsigned lim = 1;
`ifdef ACCUM_DISPLAY_SIGNED_EN
    for (int i = 0; i < int'(N) - 1; i++) lim *= 10;
`else
    for (int i = 0; i < int'(N); i++) lim *= 10;
`endif
    return magnitude(v) >= lim;
  endfunction

  function automatic disp_t render(input logic [BITS-1:0] v);
    disp_t r;
    longint unsigned m;
    int d;
    r = '1;
    m = magnitude(v);
    if (is_overflow(v)) begin
      for (int i = 0; i < int'(N); i++) r[i] = 8'hBF;
    end else begin
      d = 0;
      do begin
        r[d] = {1'b1, ~glyph[int'(m % 10)]};
        m = m / 10;
        d++;
      end while (m != 0);
`ifdef ACCUM_DISPLAY_SIGNED_EN
      if (v[BITS-1]) r[d] = 8'hBF;
`endif
    end
    return r;
  endfunction

  // Behavioural model: conversion is a fixed countdown that captures accum one
  // cycle after a change is noticed; the scan is a free-running cycle count.
  bit              m_valid = 0;
  logic [N-1:0]    m_anode;
  logic [7:0]      m_cath;
  bit              m_busy, m_ovf, m_dirty;
  logic [BITS-1:0] m_last, m_val;
  int              m_left, m_idx, m_tick;
  disp_t           m_disp;

  always @(posedge clk) begin
    m_valid = 1;
    if (reset) begin
      m_anode = '1; m_cath = '1; m_busy = 0; m_ovf = 0; m_dirty = 1;
      m_last = '0; m_val = '0; m_left = 0; m_idx = 0; m_tick = 0; m_disp = '1;
    end else begin
      m_anode = ~(N'(1) << m_idx);
      m_cath  = m_disp[m_idx];
      if (m_tick == int'(R) - 1) begin
        m_tick = 0;
        m_idx  = (m_idx + 1) % int'(N);
      end else m_tick++;
      if (m_left == 0) begin
        if (m_dirty || bus.accum != m_last) begin
          m_left = int'(LAT);
          m_busy = 1;
        end
      end else begin
        if (m_left == int'(LAT)) begin
          m_val = bus.accum; m_last = bus.accum; m_dirty = 0;
        end
        m_left--;
        if (m_left == 0) begin
          m_disp = render(m_val);
          m_ovf  = is_overflow(m_val);
          m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("anode", bus.anode, m_anode);
      check("cathode", bus.cathode, m_cath);
      check("busy", bus.busy, m_busy);
      check("overflow", bus.overflow, m_ovf);
    end
  end

  task automatic expect_digit(input int d, input logic [7:0] exp, input string name);
    bit seen = 0;
    for (int c = 0; c < int'(2 * R * N) && !seen; c++) begin
      @(negedge clk);
      if (bus.anode == ~(N'(1) << d)) begin
        check(name, bus.cathode, exp);
        seen = 1;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s timeout: digit %0d never scanned", name, d);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    bit ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (bus.busy == lvl) ok = 1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s timeout: busy stuck at %0b", name, !lvl);
    end
  endtask

  initial begin
    int cnt;
    logic [BITS-1:0] v;
    reset = 1'b1;
    bus.accum = '0;
    repeat (3) @(negedge clk);
    check("rst_anode", bus.anode, 8'hFF);
    check("rst_cathode", bus.cathode, 8'hFF);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    reset = 1'b0;

    repeat (37) @(negedge clk);
    check("zero_overflow", bus.overflow, 1'b0);
    expect_digit(0, 8'hC0, "zero_d0");
    expect_digit(1, 8'hFF, "zero_d1");

    bus.accum = 32'd12345678;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else if (cnt != 0) break;
    end
    check("busy_len", cnt, 34);
    expect_digit(7, 8'hF9, "dec_d7_1");
    expect_digit(3, 8'h92, "dec_d3_5");
    expect_digit(0, 8'h80, "dec_d0_8");

`ifdef ACCUM_DISPLAY_SIGNED_EN
    bus.accum = 32'hFFFFFFF9;
    repeat (40) @(negedge clk);
    check("neg7_overflow", bus.overflow, 1'b0);
    expect_digit(1, 8'hBF, "neg7_d1_minus");
    expect_digit(0, 8'hF8, "neg7_d0_7");
    expect_digit(2, 8'hFF, "neg7_d2_blank");
    bus.accum = 32'h80000000;
    repeat (40) @(negedge clk);
    check("minint_overflow", bus.overflow, 1'b1);
`else
    bus.accum = 32'd100000000;
    repeat (40) @(negedge clk);
    check("big_overflow", bus.overflow, 1'b1);
    expect_digit(3, 8'hBF, "big_d3_dash");
    bus.accum = 32'd99999999;
    repeat (40) @(negedge clk);
    check("max_overflow", bus.overflow, 1'b0);
    expect_digit(7, 8'h90, "max_d7_9");
`endif

    bus.accum = 32'd5;
    repeat (10) @(negedge clk);
    bus.accum = 32'd9;
    wait_busy(1'b0, "five_done");
    @(negedge clk);
    expect_digit(0, 8'h92, "first_done_5");
    repeat (80) @(negedge clk);
    expect_digit(0, 8'h90, "then_9");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom;
        1: v = BITS'($urandom_range(0, 99999999));
        2: v = BITS'($urandom_range(0, 999));
        3: v = 32'd0 - BITS'($urandom_range(0, 9999999));
        default: v = ($urandom_range(0, 1) != 0) ? 32'd9999999 : 32'd10000000;
      endcase
      bus.accum = v;
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midscan_reset_anode", bus.anode, 8'hFF);
    reset = 1'b0;
    repeat (45) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
